// File: rtl/ifs_capture_bank_if.sv
// ifs_capture_bank_if: capture bank data/control bundle; master drives SP/D/CLRF, slave returns Q/QV/RISE/FALL/CHG
interface ifs_capture_bank_if #(
  parameter int WIDTH = 8
);
  logic             SP;
  logic [WIDTH-1:0] D;
  logic             CLRF;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic [WIDTH-1:0] CHG;
  modport master (output SP, D, CLRF, input Q, QV, RISE, FALL, CHG);
  modport slave  (input SP, D, CLRF, output Q, QV, RISE, FALL, CHG);
endinterface

// File: rtl/ifs_capture_bank.sv
// ifs_capture_bank: DEPTH-stage clock-enabled WIDTH-bit input capture with fill flag, edge pulses and sticky change flags
// Ports: SCLK clock; LSR async active-high reset; GSRNET/PURNET active-low global reset nets (tie high when unused);
//        bus (slave): SP enable, D data, CLRF change clear -> Q data, QV filled, RISE/FALL pulses, CHG sticky flags
module ifs_capture_bank #(
  parameter string            GSR   = "ENABLED",
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
  input logic SCLK,
  input logic LSR,
  input logic GSRNET,
  input logic PURNET,
  ifs_capture_bank_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] stg [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];
  logic [WIDTH-1:0] q, nxt, rise, fall, chg;
  logic [CW-1:0] cnt;
  logic srn, rst, full;
  assign srn  = (GSR == "DISABLED") ? PURNET : (GSRNET & PURNET);
  assign rst  = LSR | ~srn;
  assign q    = stg[DEPTH-1];
  assign nxt  = src[DEPTH-1];
  assign full = cnt == CW'(DEPTH);
  // src[k] is what stage k loads on an enabled edge; its last entry is the next Q
  always_comb begin
    src[0] = bus.D;
    for (int k = 1; k < DEPTH; k++) src[k] = stg[k-1];
  end
  // edges are reported only once the pipe holds real samples, so INIT never produces a pulse;
  // CHG folds in the registered pulses and therefore trails RISE/FALL by one edge
  always_ff @(posedge SCLK or posedge rst)
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= INIT;
      cnt  <= '0;
      rise <= '0;
      fall <= '0;
      chg  <= '0;
    end else begin
      if (bus.SP) begin
        for (int k = 0; k < DEPTH; k++) stg[k] <= src[k];
        cnt <= full ? cnt : cnt + CW'(1);
      end
      rise <= (bus.SP && full) ? (nxt & ~q) : '0;
      fall <= (bus.SP && full) ? (~nxt & q) : '0;
      chg  <= (bus.CLRF ? '0 : chg) | rise | fall;
    end
  assign bus.Q    = q;
  assign bus.QV   = full;
  assign bus.RISE = rise;
  assign bus.FALL = fall;
  assign bus.CHG  = chg;
endmodule
